csense_spi_ctrl: RTL

//  SPI master for the current-sense ADCs, directly downstream of the 2-bit csense_cs_n PIO.
//  The PIO out_port selects the target device(s): active-low, one bit per device.

---
 rtl/csense_spi_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/csense_spi_ctrl.sv
// ----------------------------------------------------------------------------
// csense_spi_ctrl
//   SPI master (mode 0, MSB first) for the current-sense ADCs. It latches the
//   active-low device selection coming from the csense_cs_n PIO on an accepted
//   start, then runs one DATA_W-bit full-duplex transfer:
//      IDLE -> SETUP (CLK_DIV cycles, cs low, sclk low)
//           -> SHIFT (DATA_W sclk periods of 2*CLK_DIV cycles, sclk rises first)
//           -> HOLD  (CLK_DIV cycles, cs low, sclk low) -> IDLE
//   done pulses (and rx_data updates) in the same cycle that cs deasserts.
//
//   Handshake: start is a one-cycle request sampled only in IDLE. It is
//   accepted when at least one cs_req_n bit is low; with no device selected it
//   is rejected with a one-cycle err_nosel pulse. A start while busy is dropped
//   without any indication. There is no back-pressure on done/rx_data.
//
//   Optional feature: define CSENSE_SPI_LOOPBACK_EN to add the loopback input.
//   While loopback=1 the receive sampler takes spi_mosi instead of spi_miso.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   cs_req_n         device select from PIO (0 = selected), latched on start
//   start, tx_data   transfer request and word to send
//   busy, done       transfer in progress / one-cycle completion pulse
//   rx_data          last received word, held until the next done
//   err_nosel        one-cycle pulse for a start with no device selected
//   spi_sclk/mosi/miso/cs_n   SPI bus
//   loopback         (CSENSE_SPI_LOOPBACK_EN only) internal mosi->sampler loop
// ----------------------------------------------------------------------------
module csense_spi_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 16,
   parameter int N_CS    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_CS-1:0]   cs_req_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              err_nosel,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [N_CS-1:0]   spi_cs_n
`ifdef CSENSE_SPI_LOOPBACK_EN
   ,
   input  logic              loopback
`endif
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic [N_CS-1:0]     cs_q, cs_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                sample_bit;

`ifdef CSENSE_SPI_LOOPBACK_EN
   assign sample_bit = loopback ? mosi_q : spi_miso;
`else
   assign sample_bit = spi_miso;
`endif

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      cs_d      = cs_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (|(~cs_req_n)) begin
                  state_d = SETUP;
                  cs_d    = cs_req_n;
                  tx_sh_d = tx_data;
                  mosi_d  = tx_data[DATA_W-1];
                  busy_d  = 1'b1;
                  div_d   = '0;
                  bit_d   = '0;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end

         SETUP: begin
            if (div_q == DIV_LAST) begin
               // First rising sclk edge; capture bit DATA_W-1 from the slave.
               state_d = SHIFT;
               div_d   = '0;
               sclk_d  = 1'b1;
               rx_sh_d = {rx_sh_q[DATA_W-2:0], sample_bit};
            end else begin
               div_d   = div_q + DIV_ONE;
            end
         end

         SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + DIV_ONE;
            end else begin
               div_d = '0;
               if (sclk_q) begin
                  // Falling edge: advance transmit word; after the final bit
                  // the line is parked at 0.
                  sclk_d  = 1'b0;
                  tx_sh_d = tx_sh_q << 1;
                  mosi_d  = (bit_q == BIT_LAST) ? 1'b0 : tx_sh_q[DATA_W-2];
               end else if (bit_q == BIT_LAST) begin
                  // Low half of the last period has elapsed.
                  state_d = HOLD;
               end else begin
                  sclk_d  = 1'b1;
                  bit_d   = bit_q + BIT_ONE;
                  rx_sh_d = {rx_sh_q[DATA_W-2:0], sample_bit};
               end
            end
         end

         HOLD: begin
            if (div_q == DIV_LAST) begin
               state_d   = IDLE;
               div_d     = '0;
               bit_d     = '0;
               cs_d      = '1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
            end else begin
               div_d     = div_q + DIV_ONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         cs_q      <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rx_data   = rx_data_q;
   assign err_nosel = err_q;
   assign spi_sclk  = sclk_q;
   assign spi_mosi  = mosi_q;
   assign spi_cs_n  = cs_q;

endmodule
